// File: rtl/fifo_uart_tx.sv
// Pulls one byte at a time from an upstream FIFO and serialises it as a UART frame.
// RD_EN is issued one cycle after the IDLE decision, and tx is registered. The line stalls in IDLE while tx_en=0 or the FIFO is empty.
module fifo_uart_tx #(
    parameter int f_WIDTH      = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               asyn_rst,
    input  logic [f_WIDTH-1:0] f_out,
    input  logic               f_empty,
    output logic               RD_EN,
    input  logic               tx_en,
    output logic               tx,
    output logic               tx_busy,
    output logic [15:0]        frame_cnt
);

    localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    localparam int CNT_W     = $clog2(STOP_CLKS);
    localparam int IDX_W     = (f_WIDTH > 1) ? $clog2(f_WIDTH) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(f_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [f_WIDTH-1:0] shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               rd_en_q, rd_en_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_en && !f_empty) state_d = FETCH;
            end
            FETCH: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                // f_out is valid here because RD_EN was high during FETCH
                cnt_d   = '0;
                shift_d = f_out;
                par_d   = ^f_out;
                state_d = START;
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from next-state values so the registered copies line up with state_q
        rd_en_d = (state_d == FETCH);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            rd_en_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            rd_en_q     <= rd_en_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign RD_EN     = rd_en_q;
    assign tx        = tx_q;
    assign tx_busy   = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (no parity / parity+1 stop / parity+2 stop), each fed by a small FIFO model.
module tb_fifo_uart_tx;

    logic        clk      = 1'b0;
    logic        asyn_rst = 1'b1;
    logic        tx_en    = 1'b0;
    logic [7:0]  f_out [3];
    logic [2:0]  f_empty;
    logic [2:0]  rd_en;
    logic [2:0]  tx;
    logic [2:0]  busy;
    logic [15:0] fcnt [3];

    logic [7:0]  fmem [3][8];
    int          fwr [3];
    int          frd [3];

    logic [63:0] wave [3];
    int          blen [3];
    int          idle_run [3];
    int          gap [3];
    int          rd_cnt [3];
    int          txlow_idle [3];
    int          frames_seen [3];
    logic [2:0]  busy_prev = '0;
    logic [63:0] hist_wave [3][4];
    int          hist_len [3][4];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.f_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .asyn_rst(asyn_rst), .f_out(f_out[0]), .f_empty(f_empty[0]), .RD_EN(rd_en[0]),
        .tx_en(tx_en), .tx(tx[0]), .tx_busy(busy[0]), .frame_cnt(fcnt[0]));
    fifo_uart_tx #(.f_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .asyn_rst(asyn_rst), .f_out(f_out[1]), .f_empty(f_empty[1]), .RD_EN(rd_en[1]),
        .tx_en(tx_en), .tx(tx[1]), .tx_busy(busy[1]), .frame_cnt(fcnt[1]));
    fifo_uart_tx #(.f_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .asyn_rst(asyn_rst), .f_out(f_out[2]), .f_empty(f_empty[2]), .RD_EN(rd_en[2]),
        .tx_en(tx_en), .tx(tx[2]), .tx_busy(busy[2]), .frame_cnt(fcnt[2]));

    // FIFO model with one-cycle read latency
    always_comb begin
        for (int i = 0; i < 3; i++) f_empty[i] = (fwr[i] == frd[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i] && !f_empty[i]) begin
                f_out[i] <= fmem[i][frd[i][2:0]];
                frd[i]   <= frd[i] + 1;
            end
        end
    end

    // Records the tx samples of each busy window, plus the gaps and read pulses between them
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) begin
                if (!busy_prev[i]) begin
                    wave[i] = {63'b0, tx[i]};
                    blen[i] = 1;
                    gap[i]  = idle_run[i];
                end else begin
                    wave[i] = {wave[i][62:0], tx[i]};
                    blen[i] = blen[i] + 1;
                end
                idle_run[i] = 0;
            end else begin
                if (busy_prev[i]) begin
                    hist_wave[i][frames_seen[i] % 4] = wave[i];
                    hist_len[i][frames_seen[i] % 4]  = blen[i];
                    frames_seen[i] = frames_seen[i] + 1;
                end
                idle_run[i] = idle_run[i] + 1;
                if (!tx[i]) txlow_idle[i] = txlow_idle[i] + 1;
            end
            if (rd_en[i]) rd_cnt[i] = rd_cnt[i] + 1;
            busy_prev[i] = busy[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][fwr[i][2:0]] = b;
        fwr[i] = fwr[i] + 1;
    endtask

    task automatic wait_frames(input int i, input int target);
        int n = 0;
        while (frames_seen[i] < target && n < 600) begin
            tick(1);
            n++;
        end
        chk("frames_done", 64'(frames_seen[i]), 64'(target));
    endtask

    task automatic wait_busy(input int i);
        int n = 0;
        while (!busy[i] && n < 200) begin
            tick(1);
            n++;
        end
        chk("busy_rise", 64'(busy[i]), 64'd1);
    endtask

    // Expected busy-window waveform: FETCH, LOAD, start, data LSB first, optional parity, stop
    function automatic logic [63:0] exp_wave(input logic [7:0] b, input int par, input int sb);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 2; k++) w = {w[62:0], 1'b1};
        for (int k = 0; k < 4; k++) w = {w[62:0], 1'b0};
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 4; k++) w = {w[62:0], b[j]};
        if (par != 0)
            for (int k = 0; k < 4; k++) w = {w[62:0], ^b};
        for (int k = 0; k < 4 * sb; k++) w = {w[62:0], 1'b1};
        return w;
    endfunction

    initial begin
        int bf, bf1, bf2, brd;

        // Reset is asynchronous: checked before any clock edge
        #1 asyn_rst = 1'b0;
        #1;
        chk("rst_tx", 64'(tx), 64'b111);
        chk("rst_rd_en", 64'(rd_en), 64'b000);
        chk("rst_busy", 64'(busy), 64'b000);
        chk("rst_frame_cnt", 64'(fcnt[0]), 64'd0);
        tick(3);
        asyn_rst = 1'b1;

        // Data waiting but tx_en low: nothing is fetched
        push(0, 8'hAA);
        brd = rd_cnt[0];
        tick(20);
        chk("hold_rd_en", 64'(rd_cnt[0] - brd), 64'd0);
        chk("hold_tx", 64'(tx[0]), 64'd1);
        chk("hold_busy", 64'(busy[0]), 64'd0);

        // Single byte 0xAA
        bf  = frames_seen[0];
        brd = rd_cnt[0];
        tx_en = 1'b1;
        wait_frames(0, bf + 1);
        chk("aa_wave", hist_wave[0][bf % 4], 64'h300F0F0F0FF);
        chk("aa_busy_len", 64'(hist_len[0][bf % 4]), 64'd42);
        chk("aa_rd_pulses", 64'(rd_cnt[0] - brd), 64'd1);
        chk("aa_frame_cnt", 64'(fcnt[0]), 64'd1);

        // Back-to-back 0xBB, 0xCC
        bf  = frames_seen[0];
        brd = rd_cnt[0];
        push(0, 8'hBB);
        push(0, 8'hCC);
        wait_frames(0, bf + 2);
        chk("bb_wave", hist_wave[0][bf % 4], exp_wave(8'hBB, 0, 1));
        chk("cc_wave", hist_wave[0][(bf + 1) % 4], exp_wave(8'hCC, 0, 1));
        chk("b2b_idle_gap", 64'(gap[0]), 64'd1);
        chk("b2b_rd_pulses", 64'(rd_cnt[0] - brd), 64'd2);
        chk("b2b_frame_cnt", 64'(fcnt[0]), 64'd3);

        // Parity: 0x07 -> 1, 0x03 -> 0; one and two stop bits
        bf1 = frames_seen[1];
        bf2 = frames_seen[2];
        push(1, 8'h07); push(1, 8'h03);
        push(2, 8'h07); push(2, 8'h03);
        wait_frames(1, bf1 + 2);
        wait_frames(2, bf2 + 2);
        chk("p1_07_len", 64'(hist_len[1][bf1 % 4] - 2), 64'd44);
        chk("p1_07_par", 64'(hist_wave[1][bf1 % 4][4]), 64'd1);
        chk("p1_03_par", 64'(hist_wave[1][(bf1 + 1) % 4][4]), 64'd0);
        chk("p1_07_wave", hist_wave[1][bf1 % 4], exp_wave(8'h07, 1, 1));
        chk("p1_03_wave", hist_wave[1][(bf1 + 1) % 4], exp_wave(8'h03, 1, 1));
        chk("p2_07_len", 64'(hist_len[2][bf2 % 4] - 2), 64'd48);
        chk("p2_07_par", 64'(hist_wave[2][bf2 % 4][8]), 64'd1);
        chk("p2_03_par", 64'(hist_wave[2][(bf2 + 1) % 4][8]), 64'd0);
        chk("p2_03_wave", hist_wave[2][(bf2 + 1) % 4], exp_wave(8'h03, 1, 2));
        chk("p_frame_cnt", 64'({fcnt[1], fcnt[2]}), 64'h0002_0002);

        // tx_en dropped mid-DATA: frame completes, second byte stays queued
        bf  = frames_seen[0];
        brd = rd_cnt[0];
        push(0, 8'h3C);
        push(0, 8'h42);
        wait_busy(0);
        tick(12);
        tx_en = 1'b0;
        wait_frames(0, bf + 1);
        tick(60);
        chk("drop_wave", hist_wave[0][bf % 4], exp_wave(8'h3C, 0, 1));
        chk("drop_rd_pulses", 64'(rd_cnt[0] - brd), 64'd1);
        chk("drop_fifo_empty", 64'(f_empty[0]), 64'd0);
        chk("drop_busy", 64'(busy[0]), 64'd0);
        chk("drop_frame_cnt", 64'(fcnt[0]), 64'd4);

        // Reset in DATA bit 3 of 0x42 (bit 3 is 0), applied between clock edges
        tx_en = 1'b1;
        wait_busy(0);
        tick(19);
        chk("pre_rst_tx", 64'(tx[0]), 64'd0);
        asyn_rst = 1'b0;
        #1;
        chk("abort_tx", 64'(tx[0]), 64'd1);
        chk("abort_rd_en", 64'(rd_en[0]), 64'd0);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_frame_cnt", 64'(fcnt[0]), 64'd0);
        tick(2);
        asyn_rst = 1'b1;
        brd = rd_cnt[0];
        tick(20);
        chk("post_rst_rd", 64'(rd_cnt[0] - brd), 64'd0);
        chk("post_rst_busy", 64'(busy[0]), 64'd0);
        chk("post_rst_tx", 64'(tx[0]), 64'd1);
        chk("post_rst_frame_cnt", 64'(fcnt[0]), 64'd0);

        // frame_cnt wraps from 0xFFFF
        force u_dut0.frame_cnt_q = 16'hFFFF;
        tick(1);
        release u_dut0.frame_cnt_q;
        tick(1);
        chk("preload_frame_cnt", 64'(fcnt[0]), 64'hFFFF);
        bf = frames_seen[0];
        push(0, 8'h81);
        wait_frames(0, bf + 1);
        chk("wrap_wave", hist_wave[0][bf % 4], exp_wave(8'h81, 0, 1));
        chk("wrap_frame_cnt", 64'(fcnt[0]), 64'd0);

        chk("idle_tx_low", 64'(txlow_idle[0] + txlow_idle[1] + txlow_idle[2]), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
